uart_tx_engine: RTL

- Serial UART transmitter; companion to the existing UART receive path. Uses the same frame options: 6-9 data bits, optional parity (even/odd), 1-2 stop bits.
- Accepts one parallel word per valid/ready handshake and shifts it out LSB-first on tx_o, one bit per baud strobe.
- Sits between the UART register block (data/config) and the pad.
- With baud_tick_i tied high it emits one bit per clock, matching the receiver's per-clock sampling for loopback.

---
 rtl/uart_tx_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//
// Serial UART transmitter. Accepts one parallel word per valid/ready
// handshake and shifts it out LSB-first on tx_o, one line bit per
// baud_tick_i strobe. The frame format matches the receive path:
// 6..9 data bits, optional even/odd parity, 1..2 stop bits.
//
// Frame on the line: start(0), N data bits LSB-first, [parity], stop(1) x S.
// With baud_tick_i tied high the engine emits one bit per clock.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   baud_tick_i    one-clock strobe per bit period (ignored while idle)
//   tx_valid_i     word available on data_i
//   tx_ready_o     engine idle, a word will be accepted this clock
//   data_i         word to send; bits above the data size are ignored
//   data_size_i    data bits per frame (6..9, anything else sends 8)
//   parity_size_i  1 = parity bit present
//   parity_type_i  0 = even, 1 = odd
//   stop_size_i    stop bits (1..2, 0 or 3 sends 1)
//   tx_o           registered serial line
//   tx_busy_o      frame in progress
//   tx_done_o      one-cycle pulse on the tick that ends the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_engine #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_tick_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [8:0] data_i,
    input  logic [3:0] data_size_i,
    input  logic       parity_size_i,
    input  logic       parity_type_i,
    input  logic [1:0] stop_size_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t     state_reg,      state_next;
    logic       tx_reg,         tx_next;
    logic [8:0] shift_reg,      shift_next;
    logic [3:0] size_reg,       size_next;
    logic [3:0] bit_cnt_reg,    bit_cnt_next;
    logic       parity_en_reg,  parity_en_next;
    logic       parity_bit_reg, parity_bit_next;
    logic       stop_two_reg,   stop_two_next;
    logic       stop_cnt_reg,   stop_cnt_next;
    logic       done_comb;

    // -------------------------------------------------------------------------
    // Input sanitising and parity, evaluated on the accept cycle only
    // -------------------------------------------------------------------------
    logic [3:0] data_size_san;
    logic [8:0] data_mask;
    logic [8:0] data_masked;
    logic       parity_calc;
    logic       accept;

    assign data_size_san = ((data_size_i >= 4'd6) && (data_size_i <= 4'd9))
                           ? data_size_i : 4'd8;

    // Bit gi of the word takes part in the frame when gi < N.
    for (genvar gi = 0; gi < 9; gi++) begin : g_mask
        localparam logic [3:0] BIT_IDX = 4'(gi);
        assign data_mask[gi] = (data_size_san > BIT_IDX);
    end

    assign data_masked = data_i & data_mask;
    // Even type: parity makes the total count of ones even; odd flips it.
    assign parity_calc = (^data_masked) ^ parity_type_i;

    assign accept = tx_valid_i && (state_reg == ST_IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            tx_reg         <= IDLE_LEVEL;
            shift_reg      <= '0;
            size_reg       <= 4'd8;
            bit_cnt_reg    <= '0;
            parity_en_reg  <= 1'b0;
            parity_bit_reg <= 1'b0;
            stop_two_reg   <= 1'b0;
            stop_cnt_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tx_reg         <= tx_next;
            shift_reg      <= shift_next;
            size_reg       <= size_next;
            bit_cnt_reg    <= bit_cnt_next;
            parity_en_reg  <= parity_en_next;
            parity_bit_reg <= parity_bit_next;
            stop_two_reg   <= stop_two_next;
            stop_cnt_reg   <= stop_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        tx_next         = tx_reg;
        shift_next      = shift_reg;
        size_next       = size_reg;
        bit_cnt_next    = bit_cnt_reg;
        parity_en_next  = parity_en_reg;
        parity_bit_next = parity_bit_reg;
        stop_two_next   = stop_two_reg;
        stop_cnt_next   = stop_cnt_reg;
        done_comb       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_next = IDLE_LEVEL;
                // baud_tick_i is deliberately not looked at here: a tick in
                // the accept cycle must not start the frame.
                if (accept) begin
                    shift_next      = data_masked;
                    size_next       = data_size_san;
                    parity_en_next  = parity_size_i;
                    parity_bit_next = parity_calc;
                    stop_two_next   = (stop_size_i == 2'd2);
                    state_next      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                tx_next = IDLE_LEVEL;
                // Aligning the start bit to a tick makes it a full bit period.
                if (baud_tick_i) begin
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (baud_tick_i) begin
                    tx_next      = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = size_reg - 4'd1;
                    state_next   = ST_DATA;
                end
            end

            ST_DATA: begin
                // Counter holds the number of data bits still to be driven
                // after the one currently on the line.
                if (baud_tick_i) begin
                    if (bit_cnt_reg != 4'd0) begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg - 4'd1;
                    end else if (parity_en_reg) begin
                        tx_next    = parity_bit_reg;
                        state_next = ST_PARITY;
                    end else begin
                        tx_next       = 1'b1;
                        stop_cnt_next = stop_two_reg;
                        state_next    = ST_STOP;
                    end
                end
            end

            ST_PARITY: begin
                if (baud_tick_i) begin
                    tx_next       = 1'b1;
                    stop_cnt_next = stop_two_reg;
                    state_next    = ST_STOP;
                end
            end

            ST_STOP: begin
                tx_next = 1'b1;
                if (baud_tick_i) begin
                    if (stop_cnt_reg) begin
                        stop_cnt_next = 1'b0;
                    end else begin
                        done_comb  = 1'b1;
                        tx_next    = IDLE_LEVEL;
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                tx_next    = IDLE_LEVEL;
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tx_o       = tx_reg;
    assign tx_ready_o = (state_reg == ST_IDLE);
    assign tx_busy_o  = (state_reg != ST_IDLE);
    // Combinational so that ready rises on the cycle after the pulse.
    assign tx_done_o  = done_comb;

endmodule
